tdm_demultiplexer: RTL and testbench
====================================

# tdm_demultiplexer

Time-division demultiplexer: the receive-side counterpart of the codebase's 2:1 selection logic. Takes a single serial stream of WIDTH-bit beats, framed by a start-of-frame marker, and distributes consecutive beats onto LANES parallel output lanes. A completed frame is presented as one registered parallel word with a one-cycle valid pulse. It sits after a time-multiplexed link and feeds lane-parallel consumers.

## Interface
- WIDTH, 8, bits per beat / per lane; ≥1
- LANES, 4, lanes per frame; ≥2
- CLK  in  1  single clock, all state on rising edge
- RST_N  in  1  reset, synchronous, active-low
- IN_VALID  in  1  beat present on IN_DATA this cycle
- IN_SOF  in  1  qualifies IN_VALID beat as lane 0 of a new frame
- IN_DATA  in  WIDTH  beat payload
- OUT_DATA  out  LANES*WIDTH  last complete frame; lane k at bits [k*WIDTH +: WIDTH]
- OUT_VALID  out  1  one-cycle pulse: OUT_DATA just updated
- ERR_SHORT  out  1  one-cycle pulse: frame aborted by early IN_SOF

## Operation
- No backpressure: every IN_VALID beat is consumed in its cycle.
- State IDLE (waiting for frame start), COLLECT (filling lanes). Lane counter cnt, width $clog2(LANES).
- IDLE:
  - IN_VALID & IN_SOF: hold[0] <= IN_DATA, cnt <= 1, go COLLECT.
  - IN_VALID & !IN_SOF: beat dropped, no flag, stay IDLE.
- COLLECT:
  - IN_VALID & !IN_SOF: hold[cnt] <= IN_DATA.
    - cnt == LANES-1: OUT_DATA <= {IN_DATA, hold[LANES-2:0]}, OUT_VALID <= 1, cnt <= 0, go IDLE.
    - Otherwise cnt <= cnt+1.
  - IN_VALID & IN_SOF: partial frame discarded, ERR_SHORT <= 1, hold[0] <= IN_DATA, cnt <= 1, stay COLLECT. OUT_DATA is not touched.
  - !IN_VALID: hold state. Gaps between beats are legal and unlimited.
- hold[] is internal. OUT_DATA changes only on frame completion and holds its value indefinitely otherwise.
- Counter never exceeds LANES-1. No wrap except via frame completion.

## Timing
- Reset (RST_N low at a rising edge): state IDLE, cnt 0, hold[] 0, OUT_DATA 0, OUT_VALID 0, ERR_SHORT 0.
- Reset mid-frame discards the partial frame. No ERR_SHORT.
- Latency: last beat accepted at edge N. OUT_DATA and OUT_VALID are visible after edge N, high for exactly that one cycle.
- Back-to-back frames are supported: a SOF beat in the cycle directly after completion starts the next frame at full throughput. OUT_VALID can therefore pulse every LANES cycles.
- ERR_SHORT is registered and pulses in the cycle after the offending SOF beat. OUT_VALID and ERR_SHORT are never high together.
- All outputs are driven directly from flops. There is no combinational path from inputs to outputs.

## Structure
- Package tdm_demux_pkg holds:
  - state typedef enum logic {IDLE, COLLECT}
  - lane-index helper function lane_lsb(k) = k*WIDTH
- Sub-module tdm_lane_counter:
  - Synchronous active-low reset.
  - Inputs: inc, load1 (force to 1), clr.
  - Output: cnt and last (cnt == LANES-1).
  - The top level holds the FSM, hold registers and output registers.

## Test plan
- Reset release, then SOF beats 0x11, 0x22, 0x33, 0x44 (defaults) → one cycle after the 0x44 edge, OUT_DATA = 0x44332211 and OUT_VALID high for 1 cycle. ERR_SHORT stays 0.
- Beats 0xAA, 0xBB without SOF in IDLE → dropped. OUT_DATA stays 0 and no pulses. A following SOF frame 1, 2, 3, 4 → OUT_DATA = 0x04030201.
- SOF 0x01, 0x02, then SOF 0x10, 0x20, 0x30, 0x40 → ERR_SHORT pulse after the second SOF. OUT_DATA = 0x40302010. The prior OUT_DATA is unchanged until completion.
- Two frames back-to-back with no idle cycle, with IN_VALID gaps inserted mid-frame in a second run → OUT_VALID pulses exactly twice with the correct words. Pulse spacing is 4 cycles in the gap-free case.
- RST_N low for one cycle after 2 beats of a frame → all outputs 0. A subsequent full frame completes normally with no ERR_SHORT.
- Parameter sweep LANES=2, WIDTH=1 and LANES=8, WIDTH=16 → lane ordering and last-lane detection correct.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM demultiplexer.
//   state_t  : frame-assembly FSM state (IDLE waits for SOF, COLLECT fills lanes)
//   lane_lsb : least-significant bit position of lane k in the packed output word
package tdm_demux_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  function automatic int lane_lsb(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/tdm_lane_counter.sv
// Lane index counter for frame assembly.
//   clk, rst_n : clock, synchronous active-low reset (count returns to 0)
//   inc        : advance to the next lane
//   load1      : force count to 1 (lane 0 was just written by a SOF beat)
//   clr        : return to 0 (frame complete)
//   cnt        : current lane index
//   last       : cnt is the final lane of the frame
// Priority is clr > load1 > inc; the controller never asserts more than one.
module tdm_lane_counter
  import tdm_demux_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CW    = $clog2(LANES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          load1,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          last
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load1) begin
      cnt_d = CW'(1);
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == CW'(LANES - 1));

endmodule

// File: rtl/tdm_demultiplexer.sv
// Time-division demultiplexer: gathers LANES consecutive WIDTH-bit beats,
// framed by a start-of-frame marker, into one registered parallel word.
//   CLK, RST_N : clock, synchronous active-low reset
//   IN_VALID   : beat present on IN_DATA (always consumed, no backpressure)
//   IN_SOF     : the valid beat is lane 0 of a new frame
//   IN_DATA    : beat payload
//   OUT_DATA   : last complete frame, lane k at [k*WIDTH +: WIDTH]
//   OUT_VALID  : one-cycle pulse, OUT_DATA just updated
//   ERR_SHORT  : one-cycle pulse, partial frame aborted by an early SOF
//   DBG_STATE  : current FSM state (0 = IDLE, 1 = COLLECT)
// Handshake: a beat transfers on every rising edge where IN_VALID is high;
// there is no ready, so the source never stalls. Outputs are all flops.
module tdm_demultiplexer
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   IN_VALID,
  input  logic                   IN_SOF,
  input  logic [WIDTH-1:0]       IN_DATA,
  output logic [LANES*WIDTH-1:0] OUT_DATA,
  output logic                   OUT_VALID,
  output logic                   ERR_SHORT,
  output logic                   DBG_STATE
);

  localparam int CW = $clog2(LANES);

  state_t                   state_q, state_d;
  logic [WIDTH-1:0]         hold_q [LANES];
  logic [WIDTH-1:0]         hold_d [LANES];
  logic [LANES*WIDTH-1:0]   out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     err_short_q, err_short_d;

  logic [CW-1:0]            cnt;
  logic                     cnt_last;
  logic                     cnt_inc, cnt_load1, cnt_clr;

  tdm_lane_counter #(
    .LANES (LANES),
    .CW    (CW)
  ) u_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .inc   (cnt_inc),
    .load1 (cnt_load1),
    .clr   (cnt_clr),
    .cnt   (cnt),
    .last  (cnt_last)
  );

  // State register (with hold and output registers)
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_short_q <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        hold_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_short_q <= err_short_d;
      for (int k = 0; k < LANES; k++) begin
        hold_q[k] <= hold_d[k];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (IN_VALID && IN_SOF) state_d = COLLECT;
      end
      COLLECT: begin
        if (IN_VALID && !IN_SOF && cnt_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    hold_d      = hold_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    err_short_d = 1'b0;
    cnt_inc     = 1'b0;
    cnt_load1   = 1'b0;
    cnt_clr     = 1'b0;
    case (state_q)
      IDLE: begin
        // Non-SOF beats here belong to no frame and are silently dropped.
        if (IN_VALID && IN_SOF) begin
          hold_d[0] = IN_DATA;
          cnt_load1 = 1'b1;
        end
      end
      COLLECT: begin
        if (IN_VALID) begin
          if (IN_SOF) begin
            // Restart: lane 0 of the new frame overwrites the partial one.
            err_short_d = 1'b1;
            hold_d[0]   = IN_DATA;
            cnt_load1   = 1'b1;
          end else begin
            hold_d[cnt] = IN_DATA;
            if (cnt_last) begin
              // The final beat bypasses hold so the word lands this edge.
              for (int k = 0; k < LANES - 1; k++) begin
                out_data_d[lane_lsb(k, WIDTH) +: WIDTH] = hold_q[k];
              end
              out_data_d[lane_lsb(LANES - 1, WIDTH) +: WIDTH] = IN_DATA;
              out_valid_d = 1'b1;
              cnt_clr     = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  assign OUT_DATA  = out_data_q;
  assign OUT_VALID = out_valid_q;
  assign ERR_SHORT = err_short_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Bench for tdm_demultiplexer: three instances (8x4, 1x2, 16x8) checked every
// cycle against a frame-level reference model, plus directed constants.
module tb_tdm_demultiplexer;

  localparam int LN [3] = '{4, 2, 8};
  localparam int WD [3] = '{8, 1, 16};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        v [3];
  logic        s [3];
  logic [15:0] d [3];

  logic [31:0]  o0;
  logic [1:0]   o1;
  logic [127:0] o2;
  logic         ov [3];
  logic         oe [3];
  logic         st [3];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pulse_cyc [$];

  // reference model state: frame in progress, collected beats, last frame
  bit           m_in  [3];
  int           m_n   [3];
  logic [15:0]  m_buf [3][8];
  logic [127:0] m_out [3];
  logic         m_ev  [3];
  logic         m_ee  [3];

  tdm_demultiplexer #(.WIDTH(8), .LANES(4)) dut0 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(v[0]), .IN_SOF(s[0]), .IN_DATA(d[0][7:0]),
    .OUT_DATA(o0), .OUT_VALID(ov[0]), .ERR_SHORT(oe[0]), .DBG_STATE(st[0])
  );
  tdm_demultiplexer #(.WIDTH(1), .LANES(2)) dut1 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(v[1]), .IN_SOF(s[1]), .IN_DATA(d[1][0:0]),
    .OUT_DATA(o1), .OUT_VALID(ov[1]), .ERR_SHORT(oe[1]), .DBG_STATE(st[1])
  );
  tdm_demultiplexer #(.WIDTH(16), .LANES(8)) dut2 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(v[2]), .IN_SOF(s[2]), .IN_DATA(d[2]),
    .OUT_DATA(o2), .OUT_VALID(ov[2]), .ERR_SHORT(oe[2]), .DBG_STATE(st[2])
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int i);
    logic [15:0] mask;
    mask = 16'((32'd1 << WD[i]) - 1);
    m_ev[i] = 1'b0;
    m_ee[i] = 1'b0;
    if (!rst_n) begin
      m_in[i]  = 1'b0;
      m_n[i]   = 0;
      m_out[i] = '0;
    end else if (v[i]) begin
      if (s[i]) begin
        m_ee[i]     = m_in[i];
        m_in[i]     = 1'b1;
        m_buf[i][0] = d[i] & mask;
        m_n[i]      = 1;
      end else if (m_in[i]) begin
        m_buf[i][m_n[i]] = d[i] & mask;
        m_n[i]++;
        if (m_n[i] == LN[i]) begin
          m_out[i] = '0;
          for (int k = 0; k < LN[i]; k++) begin
            m_out[i] = m_out[i] | (128'(m_buf[i][k]) << (k * WD[i]));
          end
          m_ev[i] = 1'b1;
          m_in[i] = 1'b0;
          m_n[i]  = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [127:0] obs;
    for (int i = 0; i < 3; i++) begin
      obs = (i == 0) ? 128'(o0) : (i == 1) ? 128'(o1) : o2;
      chk($sformatf("out_data%0d@%0d", i, cyc), obs, m_out[i]);
      chk($sformatf("out_valid%0d@%0d", i, cyc), 128'(ov[i]), 128'(m_ev[i]));
      chk($sformatf("err_short%0d@%0d", i, cyc), 128'(oe[i]), 128'(m_ee[i]));
      chk($sformatf("state%0d@%0d", i, cyc), 128'(st[i]), 128'(m_in[i]));
      chk($sformatf("excl%0d@%0d", i, cyc), 128'(ov[i] & oe[i]), 128'(0));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    cyc++;
    check_all();
    if (ov[0]) pulse_cyc.push_back(cyc);
  endtask

  task automatic beat(input int i, input logic sof, input logic [15:0] data);
    for (int j = 0; j < 3; j++) v[j] = 1'b0;
    v[i] = 1'b1;
    s[i] = sof;
    d[i] = data;
    cycle();
    v[i] = 1'b0;
    s[i] = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int j = 0; j < 3; j++) v[j] = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    gap(1);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b0; s[i] = 1'b0; d[i] = '0;
      m_in[i] = 1'b0; m_n[i] = 0; m_out[i] = '0; m_ev[i] = 1'b0; m_ee[i] = 1'b0;
    end
    rst_n = 1'b0;
    gap(2);
    rst_n = 1'b1;
    gap(1);

    // basic frame
    beat(0, 1, 16'h11); beat(0, 0, 16'h22); beat(0, 0, 16'h33); beat(0, 0, 16'h44);
    chk("frame1_data", 128'(o0), 128'h44332211);
    chk("frame1_valid", 128'(ov[0]), 128'(1));
    gap(1);
    chk("frame1_pulse_end", 128'(ov[0]), 128'(0));

    // non-SOF beats in IDLE dropped
    do_reset();
    beat(0, 0, 16'hAA); beat(0, 0, 16'hBB);
    chk("drop_data", 128'(o0), 128'(0));
    beat(0, 1, 16'h01); beat(0, 0, 16'h02); beat(0, 0, 16'h03); beat(0, 0, 16'h04);
    chk("frame2_data", 128'(o0), 128'h04030201);

    // short frame aborted by early SOF
    beat(0, 1, 16'h01); beat(0, 0, 16'h02); beat(0, 1, 16'h10);
    chk("short_err", 128'(oe[0]), 128'(1));
    chk("short_hold_out", 128'(o0), 128'h04030201);
    beat(0, 0, 16'h20); beat(0, 0, 16'h30);
    chk("short_hold_out2", 128'(o0), 128'h04030201);
    beat(0, 0, 16'h40);
    chk("short_recover", 128'(o0), 128'h40302010);

    // back-to-back frames, no idle
    pulse_cyc.delete();
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 4; k++) beat(0, k == 0, 16'(8'h50 + f * 16 + k));
    end
    gap(1);
    chk("b2b_count", 128'(pulse_cyc.size()), 128'(2));
    if (pulse_cyc.size() == 2) chk("b2b_spacing", 128'(pulse_cyc[1] - pulse_cyc[0]), 128'(4));
    chk("b2b_last", 128'(o0), 128'h63626160);

    // frames with mid-frame gaps
    pulse_cyc.delete();
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 4; k++) begin
        beat(0, k == 0, 16'(8'h80 + f * 16 + k));
        gap(k + 1);
      end
    end
    chk("gap_count", 128'(pulse_cyc.size()), 128'(2));
    chk("gap_last", 128'(o0), 128'h93929190);

    // reset mid-frame
    beat(0, 1, 16'hC1); beat(0, 0, 16'hC2);
    do_reset();
    chk("midrst_data", 128'(o0), 128'(0));
    beat(0, 1, 16'hD1); beat(0, 0, 16'hD2); beat(0, 0, 16'hD3); beat(0, 0, 16'hD4);
    chk("midrst_frame", 128'(o0), 128'hD4D3D2D1);
    chk("midrst_noerr", 128'(oe[0]), 128'(0));

    // parameter sweep instances
    beat(1, 1, 16'h1); beat(1, 0, 16'h0);
    chk("l2_order_a", 128'(o1), 128'h1);
    beat(1, 1, 16'h0); beat(1, 0, 16'h1);
    chk("l2_order_b", 128'(o1), 128'h2);
    for (int k = 0; k < 8; k++) beat(2, k == 0, 16'(16'h1000 + k));
    chk("l8_order", o2, 128'h1007_1006_1005_1004_1003_1002_1001_1000);
    chk("l8_valid", 128'(ov[2]), 128'(1));

    // randomized traffic on all instances
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 3; i++) begin
        v[i] = ($urandom_range(0, 9) < 7);
        s[i] = ($urandom_range(0, 9) < 2);
        d[i] = 16'($urandom);
      end
      rst_n = ($urandom_range(0, 99) != 0);
      cycle();
    end
    rst_n = 1'b1;
    gap(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
